// File: rtl/fpu_pkg.sv
// fpu_pkg: FPU bus addresses, command codes, op and sequencer state types
package fpu_pkg;
  localparam logic [1:0] FPU_ADDR_STATUS = 2'd0;
  localparam logic [1:0] FPU_ADDR_RESULT = 2'd1;
  localparam logic [1:0] FPU_ADDR_CMD = 2'd2;
  localparam logic [1:0] FPU_ADDR_VALUE = 2'd3;
  localparam logic [7:0] CMD_SET_Y = 8'd1;
  localparam logic [7:0] CMD_SET_X = 8'd2;
  localparam logic [7:0] CMD_DIV = 8'd3;
  localparam logic [7:0] CMD_MUL = 8'd4;
  localparam logic [7:0] CMD_ADD = 8'd5;
  localparam logic [7:0] CMD_SUB = 8'd6;
  localparam int STATUS_BUSY_BIT = 7;
  typedef enum logic [1:0] {OP_DIV, OP_MUL, OP_ADD, OP_SUB} fpu_op_e;
  typedef enum logic [2:0] {IDLE, PREWAIT, LOADY, LOADX, OPCMD, WAIT, READ} seq_state_e;
  function automatic logic [7:0] op_cmd(input fpu_op_e o);
    return o == OP_DIV ? CMD_DIV : o == OP_MUL ? CMD_MUL : o == OP_ADD ? CMD_ADD : CMD_SUB;
  endfunction
endpackage

// File: rtl/fpu_bus_access.sv
// fpu_bus_access: one-cycle FPU strobe per accepted request followed by GAP_CYCLES idle cycles
module fpu_bus_access #(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       req_wr,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       fpu_sel,
  output logic       fpu_rd,
  output logic       fpu_wr,
  output logic [1:0] fpu_addr,
  output logic [7:0] fpu_wdata,
  input  logic [7:0] fpu_rdata
);
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
  logic stb_q, stb_d, wr_q, wr_d, accept;
  logic [1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [GW-1:0] gap_q, gap_d;
  always_comb begin
    accept = req && !stb_q && gap_q <= GW'(1);
    stb_d = accept;
    wr_d = accept ? req_wr : wr_q;
    addr_d = accept ? req_addr : addr_q;
    wdata_d = accept && req_wr ? req_wdata : wdata_q;
    gap_d = stb_q ? GW'(GAP_CYCLES) : gap_q != '0 ? gap_q - GW'(1) : gap_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stb_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      gap_q <= '0;
    end else begin
      stb_q <= stb_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      gap_q <= gap_d;
    end
  end
  assign ack = stb_q;
  assign rdata = fpu_rdata;
  assign fpu_sel = stb_q;
  assign fpu_rd = stb_q && !wr_q;
  assign fpu_wr = stb_q && wr_q;
  assign fpu_addr = addr_q;
  assign fpu_wdata = wdata_q;
endmodule

// File: rtl/fpu_host_sequencer.sv
// fpu_host_sequencer: runs one Y op X job over the FPU bus (prewait, load Y/X, op, poll, read result)
module fpu_host_sequencer import fpu_pkg::*; #(
  parameter int GAP_CYCLES = 1,
  parameter int POLL_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] y,
  input  logic [31:0] x,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        timeout,
  output logic        fpu_sel,
  output logic [1:0]  fpu_addr,
  output logic        fpu_rd,
  output logic        fpu_wr,
  output logic [7:0]  fpu_wdata,
  input  logic [7:0]  fpu_rdata
);
  localparam int PW = $clog2(POLL_LIMIT + 1) + 1;
  seq_state_e state_q, state_d;
  fpu_op_e op_q, op_d;
  logic [2:0] idx_q, idx_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [31:0] y_q, y_d, x_q, x_d, rbuf_q, rbuf_d, result_q, result_d, operand, shifted;
  logic done_q, done_d, timeout_q, timeout_d;
  logic req, req_wr, ack, is_poll;
  logic [1:0] req_addr;
  logic [7:0] req_wdata, rdata, val_byte;
  fpu_bus_access #(.GAP_CYCLES(GAP_CYCLES)) u_bus (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .fpu_sel(fpu_sel), .fpu_rd(fpu_rd),
    .fpu_wr(fpu_wr), .fpu_addr(fpu_addr), .fpu_wdata(fpu_wdata), .fpu_rdata(fpu_rdata)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    idx_d = idx_q;
    poll_d = poll_q;
    y_d = y_q;
    x_d = x_q;
    rbuf_d = rbuf_q;
    result_d = result_q;
    done_d = 1'b0;
    timeout_d = timeout_q;
    operand = state_q == LOADY ? y_q : x_q;
    val_byte = idx_q == 3'd1 ? operand[31:24] : idx_q == 3'd2 ? operand[23:16] :
               idx_q == 3'd3 ? operand[15:8] : operand[7:0];
    is_poll = state_q == PREWAIT || state_q == WAIT;
    req = state_q != IDLE;
    req_wr = state_q == LOADY || state_q == LOADX || state_q == OPCMD;
    req_addr = is_poll ? FPU_ADDR_STATUS : state_q == READ ? FPU_ADDR_RESULT :
               (state_q == OPCMD || idx_q == 3'd0) ? FPU_ADDR_CMD : FPU_ADDR_VALUE;
    req_wdata = state_q == OPCMD ? op_cmd(op_q) : idx_q != 3'd0 ? val_byte :
                state_q == LOADY ? CMD_SET_Y : CMD_SET_X;
    shifted = {rbuf_q[23:0], rdata};
    case (state_q)
      IDLE: if (start) begin
        state_d = PREWAIT;
        op_d = fpu_op_e'(op);
        y_d = y;
        x_d = x;
        idx_d = 3'd0;
        poll_d = '0;
        timeout_d = 1'b0;
      end
      PREWAIT, WAIT: if (ack) begin
        if (!rdata[STATUS_BUSY_BIT]) begin
          state_d = state_q == PREWAIT ? LOADY : READ;
          idx_d = 3'd0;
          poll_d = '0;
        end else if (poll_q >= PW'(POLL_LIMIT)) begin
          state_d = IDLE;
          timeout_d = 1'b1;
          done_d = 1'b1;
        end else poll_d = poll_q + PW'(1);
      end
      LOADY, LOADX: if (ack) begin
        idx_d = idx_q == 3'd4 ? 3'd0 : idx_q + 3'd1;
        state_d = idx_q != 3'd4 ? state_q : state_q == LOADY ? LOADX : OPCMD;
      end
      OPCMD: if (ack) begin
        state_d = WAIT;
        poll_d = '0;
      end
      READ: if (ack) begin
        rbuf_d = shifted;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd3) begin
          result_d = shifted;
          done_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= OP_DIV;
      idx_q <= '0;
      poll_q <= '0;
      y_q <= '0;
      x_q <= '0;
      rbuf_q <= '0;
      result_q <= '0;
      done_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      idx_q <= idx_d;
      poll_q <= poll_d;
      y_q <= y_d;
      x_q <= x_d;
      rbuf_q <= rbuf_d;
      result_q <= result_d;
      done_q <= done_d;
      timeout_q <= timeout_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign result = result_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_fpu_host_sequencer.sv
// tb_fpu_host_sequencer: directed scoreboard bench with a behavioural FPU slave
module tb_fpu_host_sequencer;
  logic clk = 0, rst_n = 0, start = 0;
  logic [1:0] op = 0;
  logic [31:0] y = 0, x = 0;
  logic busy, done, timeout, fpu_sel, fpu_rd, fpu_wr;
  logic [31:0] result;
  logic [1:0] fpu_addr;
  logic [7:0] fpu_wdata, fpu_rdata;
  int checks = 0, passes = 0, fails = 0, done_cnt = 0, stat_cnt = 0;
  logic [9:0] exp_wr[$];
  logic [32:0] exp_res[$];
  logic ext_busy = 0, sel_prev = 0, done_prev = 0, hold = 0, sel_x = 0, sbusy;
  logic [7:0] hold_code = 0;
  logic [31:0] sy = 0, sx = 0, sres = 0;
  logic [3:0] bcnt = 0;
  logic [1:0] rptr = 0;

  fpu_host_sequencer #(.GAP_CYCLES(1), .POLL_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .y(y), .x(x), .busy(busy), .done(done),
    .result(result), .timeout(timeout), .fpu_sel(fpu_sel), .fpu_addr(fpu_addr), .fpu_rd(fpu_rd),
    .fpu_wr(fpu_wr), .fpu_wdata(fpu_wdata), .fpu_rdata(fpu_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] calc(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b);
    case ({c, a, b})
      {8'h04, 32'h40000000, 32'h40400000}: return 32'h40C00000;
      {8'h06, 32'h40A00000, 32'h40400000}: return 32'h40000000;
      {8'h03, 32'h41200000, 32'h40000000}: return 32'h40A00000;
      {8'h04, 32'h40400000, 32'h40400000}: return 32'h41100000;
      {8'h05, 32'h40400000, 32'h3F800000}: return 32'h40800000;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  assign sbusy = bcnt != 0 || ext_busy;
  assign fpu_rdata = fpu_addr == 2'd0 ? {sbusy, 7'd0} : sres[{~rptr, 3'b000} +: 8];

  always @(posedge clk) begin
    if (fpu_wr && fpu_addr == 2'd2) begin
      if (fpu_wdata == 8'd1) sel_x <= 1'b0;
      else if (fpu_wdata == 8'd2) sel_x <= 1'b1;
      else if (fpu_wdata >= 8'd3 && fpu_wdata <= 8'd6) bcnt <= 4'd3;
    end else if (bcnt != 0) bcnt <= bcnt - 4'd1;
    if (fpu_wr && fpu_addr == 2'd3) begin
      if (sel_x) sx <= {sx[23:0], fpu_wdata};
      else sy <= {sy[23:0], fpu_wdata};
    end
    if (bcnt == 4'd1) begin
      sres <= calc(fpu_wdata, sy, sx);
      rptr <= 2'd0;
    end else if (fpu_rd && fpu_addr == 2'd1) rptr <= rptr + 2'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("rd_wr_exclusive", 32'(fpu_rd & fpu_wr), 0);
    chk("sel_matches_strobe", 32'(fpu_sel), 32'(fpu_rd | fpu_wr));
    chk("strobe_one_cycle", 32'(sel_prev & fpu_sel), 0);
    sel_prev <= fpu_sel;
    if (hold) chk("wdata_hold", 32'(fpu_wdata), 32'(hold_code));
    if (fpu_rd && fpu_addr == 2'd0) begin
      stat_cnt <= stat_cnt + 1;
      if (!fpu_rdata[7]) hold <= 1'b0;
    end
    if (fpu_wr) begin
      chk("wr_while_fpu_busy", 32'(ext_busy), 0);
      chk("wr_expected", 32'(exp_wr.size() != 0), 1);
      if (exp_wr.size() != 0) chk("wr_bus", 32'({fpu_addr, fpu_wdata}), 32'(exp_wr.pop_front()));
      if (fpu_addr == 2'd2 && fpu_wdata >= 8'd3) begin
        hold <= 1'b1;
        hold_code <= fpu_wdata;
      end
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      chk("done_single_pulse", 32'(done_prev), 0);
      chk("busy_low_at_done", 32'(busy), 0);
      chk("res_expected", 32'(exp_res.size() != 0), 1);
      if (exp_res.size() != 0) begin
        logic [32:0] e;
        e = exp_res.pop_front();
        chk("result", result, e[31:0]);
        chk("timeout", 32'(timeout), 32'(e[32]));
      end
    end
    done_prev <= done;
  end

  task automatic push_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    exp_wr.push_back({2'd2, 8'h01});
    for (int i = 3; i >= 0; i--) exp_wr.push_back({2'd3, a[8*i +: 8]});
    exp_wr.push_back({2'd2, 8'h02});
    for (int i = 3; i >= 0; i--) exp_wr.push_back({2'd3, b[8*i +: 8]});
    exp_wr.push_back({2'd2, 8'(32'd3 + 32'(o))});
    exp_res.push_back({1'b0, r});
  endtask

  task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o;
    y = a;
    x = b;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", 32'(busy), 1);
  endtask

  task automatic wait_done(input string tag);
    int n0 = done_cnt;
    for (int i = 0; i < 500 && done_cnt == n0; i++) @(negedge clk);
    chk(tag, 32'(done_cnt - n0), 1);
  endtask

  initial begin
    int n, s0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({busy, done, timeout, fpu_sel, fpu_rd, fpu_wr, fpu_addr, fpu_wdata}), 0);
    chk("reset_result", result, 0);
    rst_n = 1;
    push_op(2'd1, 32'h40000000, 32'h40400000, 32'h40C00000);
    go(2'd1, 32'h40000000, 32'h40400000);
    wait_done("mul_done");
    push_op(2'd3, 32'h40A00000, 32'h40400000, 32'h40000000);
    go(2'd3, 32'h40A00000, 32'h40400000);
    wait_done("sub_done");
    push_op(2'd1, 32'h11223344, 32'h55667788, 32'h0);
    go(2'd1, 32'h11223344, 32'h55667788);
    n = 0;
    while (!(fpu_wr && fpu_addr == 2'd2 && fpu_wdata == 8'd2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_loadx", 32'(n < 200), 1);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("abort_outs", 32'({busy, done, timeout, fpu_sel, fpu_rd, fpu_wr, fpu_addr, fpu_wdata}), 0);
    chk("abort_result", result, 0);
    @(negedge clk);
    rst_n = 1;
    exp_wr.delete();
    exp_res.delete();
    push_op(2'd1, 32'h40400000, 32'h40400000, 32'h41100000);
    go(2'd1, 32'h40400000, 32'h40400000);
    wait_done("after_abort_done");
    ext_busy = 1;
    s0 = stat_cnt;
    push_op(2'd2, 32'h40400000, 32'h3F800000, 32'h40800000);
    go(2'd2, 32'h40400000, 32'h3F800000);
    repeat (10) @(negedge clk);
    ext_busy = 0;
    wait_done("prewait_done");
    chk("prewait_polled", 32'(stat_cnt - s0 >= 5), 1);
    ext_busy = 1;
    @(negedge clk);
    s0 = stat_cnt;
    exp_res.push_back({1'b1, 32'h40800000});
    go(2'd0, 32'h12345678, 32'h9ABCDEF0);
    wait_done("timeout_done");
    chk("poll_count", 32'(stat_cnt - s0), 9);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_after_timeout", 32'({fpu_sel, busy}), 0);
    end
    chk("timeout_held", 32'(timeout), 1);
    ext_busy = 0;
    push_op(2'd0, 32'h41200000, 32'h40000000, 32'h40A00000);
    go(2'd0, 32'h41200000, 32'h40000000);
    chk("timeout_cleared", 32'(timeout), 0);
    repeat (4) @(negedge clk);
    op = 2'd1;
    y = 0;
    x = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (18) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done("div_done");
    n = done_cnt;
    repeat (40) @(negedge clk);
    chk("no_extra_done", 32'(done_cnt), 32'(n));
    chk("idle_at_end", 32'(busy), 0);
    chk("wr_queue_drained", 32'(exp_wr.size()), 0);
    chk("res_queue_drained", 32'(exp_res.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
